// File: rtl/lot_pkg.sv
// lot_pkg -- shared definitions for the parking-lot gate controller.
//   state_t        : sequence-tracking FSM states
//   CAPACITY_DEF   : default maximum lot occupancy
//   OCC_W          : width of the occupancy count
//   err_target()   : where the FSM goes after an illegal sensor transition
package lot_pkg;

   localparam int CAPACITY_DEF = 16;
   localparam int OCC_W        = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EN1,
      ST_EN2,
      ST_EN3,
      ST_EX1,
      ST_EX2,
      ST_EX3,
      ST_WAIT_CLR
   } state_t;

   // After an illegal transition a clear pair lets us start over at once;
   // anything else must first wait for both beams to clear.
   function automatic state_t err_target(input logic [1:0] ab);
      return (ab == 2'b00) ? ST_IDLE : ST_WAIT_CLR;
   endfunction

endpackage

// File: rtl/sensor_sync.sv
// sensor_sync -- single-bit multi-flop synchronizer for an asynchronous
// photo-sensor input.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, STAGES clk edges behind d_i
module sensor_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lot_gate_ctrl.sv
// lot_gate_ctrl -- tracks cars through a two-beam gate and keeps the lot
// occupancy count.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   sens_a    : outer beam (1 = blocked), asynchronous
//   sens_b    : inner beam (1 = blocked), asynchronous
//   inc / dec : one-cycle pulses on a counted entry / exit
//   occupancy : registered car count, 0..CAPACITY
//   full      : occupancy == CAPACITY
//   empty     : occupancy == 0
//   seq_err   : one-cycle pulse on an illegal sensor transition
//   overflow  : one-cycle pulse when an entry completes while full
//   underflow : one-cycle pulse when an exit completes while empty
module lot_gate_ctrl
   import lot_pkg::*;
#(
   parameter int CAPACITY    = CAPACITY_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sens_a,
   input  logic             sens_b,
   output logic             inc,
   output logic             dec,
   output logic [OCC_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             seq_err,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [OCC_W-1:0] CAP_L = OCC_W'(CAPACITY);

   logic       a_sync, b_sync;
   logic [1:0] ab;

   sensor_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk(clk), .reset(reset), .d_i(sens_a), .q_o(a_sync)
   );
   sensor_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk(clk), .reset(reset), .d_i(sens_b), .q_o(b_sync)
   );

   assign ab = {a_sync, b_sync};

   state_t           state_q, state_d;
   logic             illegal, entry_ev, exit_ev;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             inc_q, inc_d, dec_q, dec_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             seq_err_q, seq_err_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;

   // Each tracking state remembers the last legal pair; repeating it holds,
   // a one-bit step forward/back moves along the path, anything else is illegal.
   always_comb begin
      state_d   = state_q;
      illegal   = 1'b0;
      entry_ev  = 1'b0;
      exit_ev   = 1'b0;
      seq_err_d = 1'b0;
      case (state_q)
         ST_IDLE: case (ab)
            2'b00:   ;
            2'b10:   state_d = ST_EN1;
            2'b01:   state_d = ST_EX1;
            default: illegal = 1'b1;
         endcase
         ST_EN1: case (ab)
            2'b10:   ;
            2'b11:   state_d = ST_EN2;
            2'b00:   state_d = ST_IDLE;
            default: illegal = 1'b1;
         endcase
         ST_EN2: case (ab)
            2'b11:   ;
            2'b01:   state_d = ST_EN3;
            2'b10:   state_d = ST_EN1;
            default: illegal = 1'b1;
         endcase
         ST_EN3: case (ab)
            2'b01:   ;
            2'b00:   begin state_d = ST_IDLE; entry_ev = 1'b1; end
            2'b11:   state_d = ST_EN2;
            default: illegal = 1'b1;
         endcase
         ST_EX1: case (ab)
            2'b01:   ;
            2'b11:   state_d = ST_EX2;
            2'b00:   state_d = ST_IDLE;
            default: illegal = 1'b1;
         endcase
         ST_EX2: case (ab)
            2'b11:   ;
            2'b10:   state_d = ST_EX3;
            2'b01:   state_d = ST_EX1;
            default: illegal = 1'b1;
         endcase
         ST_EX3: case (ab)
            2'b10:   ;
            2'b00:   begin state_d = ST_IDLE; exit_ev = 1'b1; end
            2'b11:   state_d = ST_EX2;
            default: illegal = 1'b1;
         endcase
         ST_WAIT_CLR: if (ab == 2'b00) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (illegal) begin
         seq_err_d = 1'b1;
         state_d   = err_target(ab);
      end
   end

   // Occupancy never exceeds CAP_L, so "not full" is the same as "< CAPACITY".
   always_comb begin
      occ_d = occ_q;
      inc_d = 1'b0;
      dec_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (entry_ev) begin
         if (occ_q == CAP_L) begin
            ovf_d = 1'b1;
         end else begin
            occ_d = occ_q + OCC_W'(1);
            inc_d = 1'b1;
         end
      end else if (exit_ev) begin
         if (occ_q == '0) begin
            unf_d = 1'b1;
         end else begin
            occ_d = occ_q - OCC_W'(1);
            dec_d = 1'b1;
         end
      end
      // Flags derive from the next count so they land in the same cycle.
      full_d  = (occ_d == CAP_L);
      empty_d = (occ_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         occ_q     <= '0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         seq_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         occ_q     <= occ_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         seq_err_q <= seq_err_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign inc       = inc_q;
   assign dec       = dec_q;
   assign occupancy = occ_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign seq_err   = seq_err_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// tb_lot_gate_ctrl -- self-checking bench for lot_gate_ctrl: directed
// scenarios with literal expectations plus a randomized sensor walk, all
// compared every cycle against a behavioural gate model.
module tb_lot_gate_ctrl;

   localparam int CAP = 16;
   localparam int S   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sens_a = 1'b0, sens_b = 1'b0;
   logic       inc, dec, full, empty, seq_err, overflow, underflow;
   logic [4:0] occupancy;

   lot_gate_ctrl #(.CAPACITY(CAP), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
      .inc(inc), .dec(dec), .occupancy(occupancy), .full(full),
      .empty(empty), .seq_err(seq_err), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int inc_cnt = 0, dec_cnt = 0, err_cnt = 0, ovf_cnt = 0, unf_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A car walks around a ring of sensor pairs; entry goes 00,10,11,01,00
   // and exit goes the other way round. mode: 0 idle, 1 entering,
   // 2 exiting, 3 waiting for clear. pos = index on the current ring.
   logic [1:0] ent_ring [4];
   logic [1:0] ext_ring [4];
   logic [1:0] pipe [S];
   int m_mode, m_pos, m_occ;
   int m_inc, m_dec, m_err, m_ovf, m_unf;

   initial begin
      ent_ring[0] = 2'b00; ent_ring[1] = 2'b10; ent_ring[2] = 2'b11; ent_ring[3] = 2'b01;
      ext_ring[0] = 2'b00; ext_ring[1] = 2'b01; ext_ring[2] = 2'b11; ext_ring[3] = 2'b10;
   end

   task automatic model_clear();
      m_mode = 0; m_pos = 0; m_occ = 0;
      m_inc = 0; m_dec = 0; m_err = 0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < S; i++) pipe[i] = 2'b00;
   endtask

   task automatic model_error(input logic [1:0] v);
      m_err  = 1;
      m_mode = (v == 2'b00) ? 0 : 3;
   endtask

   task automatic model_step(input logic [1:0] v);
      logic [1:0] here, fwd, back;
      m_inc = 0; m_dec = 0; m_err = 0; m_ovf = 0; m_unf = 0;
      if (m_mode == 0) begin
         if (v == 2'b10) begin m_mode = 1; m_pos = 1; end
         else if (v == 2'b01) begin m_mode = 2; m_pos = 1; end
         else if (v == 2'b11) model_error(v);
      end else if (m_mode == 3) begin
         if (v == 2'b00) m_mode = 0;
      end else begin
         here = (m_mode == 1) ? ent_ring[m_pos] : ext_ring[m_pos];
         fwd  = (m_mode == 1) ? ent_ring[(m_pos + 1) % 4] : ext_ring[(m_pos + 1) % 4];
         back = (m_mode == 1) ? ent_ring[m_pos - 1] : ext_ring[m_pos - 1];
         if (v == here) begin
         end else if (v == fwd) begin
            if (m_pos == 3) begin
               if (m_mode == 1) begin
                  if (m_occ < CAP) begin m_occ++; m_inc = 1; end
                  else m_ovf = 1;
               end else begin
                  if (m_occ > 0) begin m_occ--; m_dec = 1; end
                  else m_unf = 1;
               end
               m_mode = 0;
            end else begin
               m_pos++;
            end
         end else if (v == back) begin
            m_pos--;
            if (m_pos == 0) m_mode = 0;
         end else begin
            model_error(v);
         end
      end
   endtask

   initial model_clear();

   // Model advances on each edge; DUT compared 1 ns later.
   always begin
      logic [1:0] v;
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         v = pipe[S-1];
         for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = {sens_a, sens_b};
         model_step(v);
      end
      #1;
      chk("inc", int'(inc), m_inc);
      chk("dec", int'(dec), m_dec);
      chk("occupancy", int'(occupancy), m_occ);
      chk("full", int'(full), (m_occ == CAP) ? 1 : 0);
      chk("empty", int'(empty), (m_occ == 0) ? 1 : 0);
      chk("seq_err", int'(seq_err), m_err);
      chk("overflow", int'(overflow), m_ovf);
      chk("underflow", int'(underflow), m_unf);
      inc_cnt += int'(inc);
      dec_cnt += int'(dec);
      err_cnt += int'(seq_err);
      ovf_cnt += int'(overflow);
      unf_cnt += int'(underflow);
   end

   // ---------------- stimulus helpers ----------------
   task automatic hold(input logic [1:0] v, input int n);
      @(negedge clk);
      {sens_a, sens_b} = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic seq4(input logic [1:0] v0, input logic [1:0] v1,
                       input logic [1:0] v2, input logic [1:0] v3);
      hold(v0, 4); hold(v1, 4); hold(v2, 4); hold(v3, 4);
   endtask

   task automatic do_reset();
      @(negedge clk);
      {sens_a, sens_b} = 2'b00;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, i0, d0, e0, o0, u0;
      logic [1:0] cur;

      do_reset();
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      $display("reset done occ=%0d empty=%0d", occupancy, empty);

      // First entry with latency measurement from 00 reaching the pins.
      i0 = inc_cnt;
      hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
      @(negedge clk);
      {sens_a, sens_b} = 2'b00;
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #2;
         if (inc) begin lat = k; break; end
      end
      chk("inc_latency", lat, S + 1);
      repeat (4) @(negedge clk);
      chk("entry1_occ", int'(occupancy), 1);
      chk("entry1_empty", int'(empty), 0);
      chk("entry1_inc_pulses", inc_cnt - i0, 1);
      $display("entry latency=%0d occ=%0d", lat, occupancy);

      // Up to 3, then an exit and a back-out.
      seq4(2'b10, 2'b11, 2'b01, 2'b00);
      seq4(2'b10, 2'b11, 2'b01, 2'b00);
      chk("occ_three", int'(occupancy), 3);
      d0 = dec_cnt;
      seq4(2'b01, 2'b11, 2'b10, 2'b00);
      chk("exit_occ", int'(occupancy), 2);
      chk("exit_dec_pulses", dec_cnt - d0, 1);
      $display("exit occ=%0d", occupancy);
      i0 = inc_cnt; d0 = dec_cnt; e0 = err_cnt;
      seq4(2'b10, 2'b11, 2'b10, 2'b00);
      chk("backout_occ", int'(occupancy), 2);
      chk("backout_pulses", (inc_cnt - i0) + (dec_cnt - d0) + (err_cnt - e0), 0);
      $display("back-out occ=%0d", occupancy);

      // Fill to capacity, then overflow.
      do_reset();
      for (int n = 0; n < CAP; n++) seq4(2'b10, 2'b11, 2'b01, 2'b00);
      chk("fill_full", int'(full), 1);
      chk("fill_occ", int'(occupancy), CAP);
      i0 = inc_cnt; o0 = ovf_cnt;
      seq4(2'b10, 2'b11, 2'b01, 2'b00);
      chk("ovf_pulses", ovf_cnt - o0, 1);
      chk("ovf_no_inc", inc_cnt - i0, 0);
      chk("ovf_occ", int'(occupancy), CAP);
      $display("overflow occ=%0d full=%0d", occupancy, full);

      // Underflow, then a direct 11 from idle.
      do_reset();
      d0 = dec_cnt; u0 = unf_cnt;
      seq4(2'b01, 2'b11, 2'b10, 2'b00);
      chk("unf_pulses", unf_cnt - u0, 1);
      chk("unf_no_dec", dec_cnt - d0, 0);
      i0 = inc_cnt; d0 = dec_cnt; e0 = err_cnt;
      hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
      chk("seqerr_pulses", err_cnt - e0, 1);
      chk("seqerr_no_count", (inc_cnt - i0) + (dec_cnt - d0), 0);
      $display("underflow+seq_err occ=%0d", occupancy);

      // Reset while in EN3 discards the car.
      do_reset();
      seq4(2'b10, 2'b11, 2'b01, 2'b00);
      hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_rst_occ", int'(occupancy), 0);
      chk("async_rst_empty", int'(empty), 1);
      @(negedge clk);
      reset = 1'b0;
      i0 = inc_cnt;
      hold(2'b00, 6);
      chk("midrst_no_inc", inc_cnt - i0, 0);
      chk("midrst_occ", int'(occupancy), 0);
      seq4(2'b10, 2'b11, 2'b01, 2'b00);
      chk("midrst_fresh_entry", int'(occupancy), 1);
      $display("mid-sequence reset occ=%0d", occupancy);

      // Random walk on the sensor pair, mostly single-bit changes.
      cur = 2'b00;
      for (int t = 0; t < 3000; t++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 80) cur[$urandom_range(0, 1)] = ~cur[$urandom_range(0, 1)];
         else if (r < 85) cur = ~cur;
         if ($urandom_range(0, 399) == 0) do_reset();
         hold(cur, int'($urandom_range(1, 5)));
      end
      hold(2'b00, 6);
      $display("random walk done inc=%0d dec=%0d err=%0d ovf=%0d unf=%0d",
               inc_cnt, dec_cnt, err_cnt, ovf_cnt, unf_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lot_gate_ctrl.md
LOT_GATE_CTRL -- requirements
Module: lot_gate_ctrl

Interface
REQ-001 Parameter CAPACITY, default 16, is the maximum lot occupancy (1..31).
REQ-002 Parameter SYNC_STAGES, default 2, is the flop depth of each sensor synchronizer (>=2).
REQ-003 Port clk, input, 1, is the single rising-edge clock.
REQ-004 Port reset, input, 1, is an asynchronous active-high reset.
REQ-005 Port sens_a, input, 1, is the asynchronous outer photo-sensor (1 = beam blocked).
REQ-006 Port sens_b, input, 1, is the asynchronous inner photo-sensor (1 = beam blocked).
REQ-007 Port inc, output, 1, is a one-cycle pulse that drives the display increment on a counted entry.
REQ-008 Port dec, output, 1, is a one-cycle pulse that drives the display decrement on a counted exit.
REQ-009 Port occupancy, output, 5, is the registered car count, 0..CAPACITY.
REQ-010 Port full, output, 1, is high when occupancy == CAPACITY.
REQ-011 Port empty, output, 1, is high when occupancy == 0.
REQ-012 Port seq_err, output, 1, is a one-cycle pulse on an illegal sensor transition.
REQ-013 Port overflow, output, 1, is a one-cycle pulse when an entry completes while full.
REQ-014 Port underflow, output, 1, is a one-cycle pulse when an exit completes while empty.

Function
REQ-015 The block SHALL pass each sensor through SYNC_STAGES flops; the FSM uses only the synchronized pair {a,b}.
REQ-016 The FSM SHALL implement the states IDLE, EN1, EN2, EN3, EX1, EX2, EX3 and WAIT_CLR.
REQ-017 From IDLE, {a,b} = 10 SHALL go to EN1, 01 SHALL go to EX1, 00 SHALL hold, and 11 SHALL go to WAIT_CLR with a seq_err pulse.
REQ-018 Entry path transitions SHALL be:
- EN1: 11 to EN2; 00 to IDLE (abort).
- EN2: 01 to EN3; 10 to EN1 (backing out).
- EN3: 00 to IDLE with an entry event; 11 to EN2.
REQ-019 Exit path transitions SHALL mirror the entry path with a and b swapped (EX1 on 01, EX2 on 11, EX3 on 10, exit event on 00 from EX3).
REQ-020 An unchanged input SHALL hold the current state.
REQ-021 Any transition in which both bits change, or which is not listed above, SHALL pulse seq_err, go to IDLE if the input is 00, and otherwise go to WAIT_CLR.
REQ-022 WAIT_CLR SHALL exit to IDLE only on 00, and SHALL produce no events.
REQ-023 An entry event with occupancy < CAPACITY SHALL increment occupancy and pulse inc.
REQ-024 An entry event with occupancy == CAPACITY SHALL pulse overflow instead, with occupancy and inc unchanged.
REQ-025 An exit event with occupancy > 0 SHALL decrement occupancy and pulse dec.
REQ-026 An exit event with occupancy == 0 SHALL pulse underflow instead, with occupancy and dec unchanged.
REQ-027 Latency SHALL be exactly SYNC_STAGES+1 clk edges from the 00 settling on the sensor pins to inc/dec/occupancy updating.
REQ-028 inc and dec SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-029 full and empty SHALL be registered in the same cycle as occupancy, so they are never stale relative to it.
REQ-030 An aborted or backed-out sequence SHALL produce no inc, dec or error pulse.

Reset
REQ-031 Asserting reset SHALL immediately force FSM to IDLE, all synchronizer flops to 0, occupancy to 0, empty to 1, and full, inc, dec, seq_err, overflow, underflow to 0.
REQ-032 A reset asserted mid-sequence SHALL discard the sequence and emit no pulse.
REQ-033 After reset deasserts, the block SHALL require a fresh sequence from IDLE.

Structure
REQ-034 Shared package lot_pkg SHALL hold the FSM state enum, the CAPACITY default and the occupancy width constant (5).
REQ-035 Sub-module sensor_sync (SYNC_STAGES-deep synchronizer, 1 bit) SHALL be instantiated once per sensor.

Verification
REQ-036 Reset, then sens {a,b} 10,11,01,00 each held 4 cycles -> one inc pulse at SYNC_STAGES+1 edges after 00, occupancy=1, empty=0.
REQ-037 From occupancy=3, sequence 01,11,10,00 -> one dec pulse, occupancy=2; sequence 10,11,10,00 (back-out) -> no pulses, occupancy=2.
REQ-038 16 entries from reset, then a 17th entry -> full=1 after the 16th, 17th gives overflow pulse only, occupancy stays 16.
REQ-039 From empty, an exit sequence -> underflow pulse, no dec; IDLE to 11 directly -> seq_err, WAIT_CLR until 00, no inc/dec.
REQ-040 Reset asserted while in EN3, released, then 00 applied -> no inc, occupancy=0, FSM in IDLE.
